// File: rtl/vote_tally.sv
// vote_tally: session-based N-voter threshold voter with one-vote-per-voter enforcement and timeout
module vote_tally #(
  parameter int N = 3,
  parameter int TIMEOUT = 16,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] threshold,
  input  logic [N-1:0]  ballot_en,
  input  logic [N-1:0]  ballot_val,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timed_out,
  output logic [CW-1:0] yes_count,
  output logic [CW-1:0] no_count,
  output logic [CW-1:0] abstain_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state;
  logic [CW-1:0] thr, yes_cnt, no_cnt, y_add, n_add, y_nxt, n_nxt;
  logic [N-1:0] voted, acc, voted_nxt;
  logic [TW-1:0] timer;
  logic all_in, tmo;
  always_comb begin
    acc = ballot_en & ~voted;
    voted_nxt = voted | acc;
    y_add = '0;
    n_add = '0;
    for (int i = 0; i < N; i++) begin
      y_add = y_add + CW'(acc[i] & ballot_val[i]);
      n_add = n_add + CW'(acc[i] & ~ballot_val[i]);
    end
    y_nxt = yes_cnt + y_add;
    n_nxt = no_cnt + n_add;
    all_in = &voted_nxt;
    tmo = timer == TW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      timed_out <= 1'b0;
      yes_count <= '0;
      no_count <= '0;
      abstain_count <= '0;
      thr <= '0;
      voted <= '0;
      yes_cnt <= '0;
      no_cnt <= '0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= COLLECT;
            busy <= 1'b1;
            thr <= threshold;
            voted <= '0;
            yes_cnt <= '0;
            no_cnt <= '0;
            timer <= '0;
          end
        end
        COLLECT: begin
          voted <= voted_nxt;
          yes_cnt <= y_nxt;
          no_cnt <= n_nxt;
          timer <= timer + 1'b1;
          if (all_in || tmo) begin
            state <= DONE;
            done <= 1'b1;
            pass <= y_nxt >= thr;
            timed_out <= !all_in;
            yes_count <= y_nxt;
            no_count <= n_nxt;
            abstain_count <= CW'(N) - y_nxt - n_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: scoreboard bench for vote_tally on a 3-voter and a 5-voter instance
module tb_vote_tally;
  typedef struct {int pass, to, y, n, a;} exp_t;
  logic clk, rst;
  logic start3, start5;
  logic [1:0] thr3, yes3, no3, ab3;
  logic [2:0] thr5, yes5, no5, ab5;
  logic [2:0] en3, val3;
  logic [4:0] en5, val5;
  logic busy3, done3, pass3, to3, busy5, done5, pass5, to5;
  exp_t q3[$], q5[$];
  int n_cmp = 0, n_bad = 0;
  vote_tally #(.N(3), .TIMEOUT(4)) d3 (
    .clk(clk), .rst(rst), .start(start3), .threshold(thr3), .ballot_en(en3), .ballot_val(val3),
    .busy(busy3), .done(done3), .pass(pass3), .timed_out(to3),
    .yes_count(yes3), .no_count(no3), .abstain_count(ab3)
  );
  vote_tally #(.N(5), .TIMEOUT(16)) d5 (
    .clk(clk), .rst(rst), .start(start5), .threshold(thr5), .ballot_en(en5), .ballot_val(val5),
    .busy(busy5), .done(done5), .pass(pass5), .timed_out(to5),
    .yes_count(yes5), .no_count(no5), .abstain_count(ab5)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go3(input int t);
    start3 = 1'b1;
    thr3 = 2'(t);
    tick();
    start3 = 1'b0;
  endtask
  task automatic bal3(input logic [2:0] e, input logic [2:0] v);
    en3 = e;
    val3 = v;
    tick();
    en3 = '0;
    val3 = '0;
  endtask
  task automatic push3(input int p, input int t, input int y, input int n, input int a);
    exp_t e;
    e.pass = p; e.to = t; e.y = y; e.n = n; e.a = a;
    q3.push_back(e);
  endtask
  task automatic push5(input int p, input int t, input int y, input int n, input int a);
    exp_t e;
    e.pass = p; e.to = t; e.y = y; e.n = n; e.a = a;
    q5.push_back(e);
  endtask
  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) chk("d3_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q3.pop_front();
        chk("d3_pass", pass3, e.pass);
        chk("d3_timed_out", to3, e.to);
        chk("d3_yes", yes3, e.y);
        chk("d3_no", no3, e.n);
        chk("d3_abstain", ab3, e.a);
        chk("d3_busy_in_done", busy3, 1);
      end
    end
  end
  always @(negedge clk) begin
    if (done5) begin
      if (q5.size() == 0) chk("d5_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q5.pop_front();
        chk("d5_pass", pass5, e.pass);
        chk("d5_timed_out", to5, e.to);
        chk("d5_yes", yes5, e.y);
        chk("d5_no", no5, e.n);
        chk("d5_abstain", ab5, e.a);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [2:0] v;
    int pc;
    rst = 1'b1;
    start3 = 0; thr3 = 0; en3 = 0; val3 = 0;
    start5 = 0; thr5 = 0; en5 = 0; val5 = 0;
    repeat (2) tick();
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    chk("rst_pass", pass3, 0);
    chk("rst_timed_out", to3, 0);
    chk("rst_yes", yes3, 0);
    chk("rst_abstain5", ab5, 0);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      pc = $countones(v);
      go3(2);
      chk("d3_busy_collect", busy3, 1);
      push3(pc >= 2 ? 1 : 0, 0, pc, 3 - pc, 0);
      bal3(3'b111, v);
      chk("d3_done_latency", done3, 1);
      tick();
      chk("d3_done_one_cycle", done3, 0);
    end
    go3(2);
    push3(0, 0, 1, 2, 0);
    bal3(3'b001, 3'b001);
    bal3(3'b001, 3'b000);
    bal3(3'b010, 3'b000);
    bal3(3'b100, 3'b000);
    tick();
    bal3(3'b111, 3'b111);
    chk("d3_idle_ballot_busy", busy3, 0);
    go3(1);
    push3(1, 1, 1, 0, 2);
    start3 = 1'b1;
    repeat (3) bal3(3'b000, 3'b000);
    start3 = 1'b0;
    bal3(3'b100, 3'b100);
    chk("d3_timeout_done", done3, 1);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick();
    chk("d3_start_in_done_ignored", busy3, 0);
    go3(3);
    push3(1, 0, 3, 0, 0);
    bal3(3'b001, 3'b001);
    repeat (2) bal3(3'b000, 3'b000);
    bal3(3'b110, 3'b110);
    tick();
    start5 = 1'b1;
    thr5 = 3'd0;
    tick();
    start5 = 1'b0;
    push5(1, 1, 0, 0, 5);
    repeat (17) tick();
    start5 = 1'b1;
    thr5 = 3'd6;
    tick();
    start5 = 1'b0;
    push5(0, 0, 5, 0, 0);
    en5 = 5'b11111;
    val5 = 5'b11111;
    tick();
    en5 = '0;
    val5 = '0;
    tick();
    go3(2);
    bal3(3'b001, 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_done", done3, 0);
    chk("mid_rst_busy", busy3, 0);
    chk("mid_rst_pass", pass3, 0);
    chk("mid_rst_yes", yes3, 0);
    repeat (3) tick();
    go3(2);
    push3(1, 0, 2, 1, 0);
    bal3(3'b111, 3'b011);
    repeat (3) tick();
    chk("d3_queue_drained", q3.size(), 0);
    chk("d5_queue_drained", q5.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vote_tally.md
Name: vote_tally

Overview:
Parametrised, session-based majority/threshold voter. It generalises the fixed 3-input combinational majority function to N voters with a programmable threshold. Ballots are collected over multiple cycles, with one-vote-per-voter enforcement and a timeout. It registers a pass/fail verdict plus yes/no/abstain counts for downstream control logic.

Parameters:
N, 3, number of voters (≥1)
TIMEOUT, 16, max cycles spent in COLLECT before forced close (≥1)
CW, $clog2(N+1), count width (derived localparam, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  open a voting session; honoured only in IDLE
threshold  in  CW  yes-votes required to pass; sampled on accepted start
ballot_en  in  N  bit i high = voter i casts a ballot this cycle
ballot_val  in  N  bit i = voter i's vote (1 yes, 0 no); qualified by ballot_en[i]
busy  out  1  high in COLLECT and DONE
done  out  1  one-cycle pulse when the verdict becomes valid
pass  out  1  verdict: yes_count ≥ latched threshold
timed_out  out  1  session closed by timeout, not by full participation
yes_count  out  CW  yes ballots in last session
no_count  out  CW  no ballots in last session
abstain_count  out  CW  N − (yes+no) for last session

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; busy, done, pass, timed_out = 0; all counts = 0; voted mask and timer cleared. Reset takes priority over everything, including mid-session, where the session is discarded with no done pulse.
- FSM states: IDLE, COLLECT, DONE.
- IDLE: start=1 → COLLECT next cycle. Latch threshold, clear voted mask, yes/no counters and timer. Output results (pass, counts, timed_out) keep the previous session's values until then. Ballots in IDLE are ignored.
- COLLECT: each cycle, accept ballot from voter i iff ballot_en[i]=1 and voted[i]=0. Set voted[i] and increment yes or no per ballot_val[i]. Several voters may ballot in the same cycle; all accepted ballots are counted. Repeat ballots are silently ignored, so the first vote stands. start is ignored.
- Timer counts cycles in COLLECT, starting at 0 on the first COLLECT cycle.
- Completion: if all voters have voted (including ballots accepted this cycle) → DONE next cycle with timed_out=0.
- Timeout: otherwise, if timer = TIMEOUT−1 → DONE next cycle with timed_out=1. Ballots on that final cycle still count. When completion and timeout coincide, completion wins (timed_out=0).
- DONE (exactly one cycle): done=1. pass, counts and timed_out are valid from this cycle and held until the next accepted start. Next state is IDLE. start is ignored in DONE.
- Latency: start accepted at edge t; first ballot cycle t+1; ballot completing the vote at edge u → done=1 during cycle u+1.
- Arithmetic: counts are CW bits and cannot overflow (max N). abstain_count = N − yes − no. threshold=0 → pass=1 always. threshold > N → pass=0 always. Compare is unsigned.
- N=3, threshold=2 reproduces the 3-input majority truth table when all three voters ballot together.
- No X on outputs after reset. ballot_val bits whose ballot_en is low are don't-care.

Test Plan:
- N=3, threshold=2, start, then one cycle with ballot_en=111 sweeping ballot_val 000..111 over 8 sessions → pass=0,0,0,1,0,1,1,1. done pulses 2 cycles after start; yes_count matches popcount.
- N=3, threshold=2: voter0 votes yes, then voter0 votes no again, then voters 1 and 2 vote no on separate cycles → repeat ignored; yes=1, no=2, pass=0, timed_out=0.
- N=3, TIMEOUT=4, threshold=1: only voter2 votes yes, in the 4th COLLECT cycle → accepted. done on the next cycle with timed_out=1, yes=1, abstain=2, pass=1.
- Completion on the same cycle as timeout (last two voters ballot at timer=TIMEOUT−1) → timed_out=0, abstain=0.
- threshold=0 with zero ballots → pass=1, abstain=N. threshold=N+1 (N=5, CW=3, value 6) with all yes → pass=0.
- Assert rst mid-COLLECT → no done pulse; all outputs 0 next cycle. start asserted during COLLECT/DONE → ignored; IDLE ballots not counted in the following session.
